// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder slice.
package dmem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmemStateT;

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word storage with per-byte write enables.
// Read data is registered and updated on every enabled access.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic                           we,
  input  logic [BE_W-1:0]                be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [DATA_W-1:0]              wdata,
  output logic [DATA_W-1:0]              rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned b = 0; b < BE_W; b++) begin
          if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: valid/ready request in, held response out.
// Address/alignment fault checking is compiled in only when DMEM_ERR_CHECK_EN is defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  dmemStateT         state;
  logic [CNT_W-1:0]  waitCnt;
  logic              capWe;
  logic [ADDR_W-1:0] capAddr;
  logic [DATA_W-1:0] capWdata;
  logic [BE_W-1:0]   capBe;
  logic              reqReady;
  logic              rspValid;
  logic              loadOk;

  logic              accept;
  logic              accessNow;
  logic              fault;
  logic              selWe;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;
  logic [BE_W-1:0]   selBe;
  logic [DATA_W-1:0] arrRdata;

  assign accept = reqReady && req_valid;

  // With zero wait states the storage access lands on the accept edge itself,
  // so the live request bypasses the capture registers while in IDLE.
  always_comb begin
    selWe    = capWe;
    selAddr  = capAddr;
    selWdata = capWdata;
    selBe    = capBe;
    if (state == IDLE) begin
      selWe    = req_we;
      selAddr  = req_addr;
      selWdata = req_wdata;
      selBe    = req_be;
    end
  end

  assign accessNow = (WAIT_CYCLES == 0) ? accept
                                        : (state == WAIT && waitCnt == CNT_W'(1));

`ifdef DMEM_ERR_CHECK_EN
  logic rspErr;

  assign fault = (selAddr >= ADDR_W'(4 * DEPTH_WORDS)) || (selAddr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) rspErr <= 1'b0;
    else if (accessNow) rspErr <= fault;
    else if (state == RESP && rsp_ready) rspErr <= 1'b0;
  end

  assign rsp_err = rspErr;
`else
  logic unusedAddrBits;

  assign fault          = 1'b0;
  assign rsp_err        = 1'b0;
  assign unusedAddrBits = &{1'b0, selAddr[ADDR_W-1:IDX_W+2], selAddr[1:0]};
`endif

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) uArray (
    .clk  (clk),
    .en   (accessNow && !fault && !rst),
    .we   (selWe),
    .be   (selBe),
    .idx  (selAddr[IDX_W+1:2]),
    .wdata(selWdata),
    .rdata(arrRdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      waitCnt  <= '0;
      reqReady <= 1'b1;
      rspValid <= 1'b0;
      loadOk   <= 1'b0;
      capWe    <= 1'b0;
      capAddr  <= '0;
      capWdata <= '0;
      capBe    <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          capWe    <= req_we;
          capAddr  <= req_addr;
          capWdata <= req_wdata;
          capBe    <= req_be;
          reqReady <= 1'b0;
          if (WAIT_CYCLES == 0) begin
            state    <= RESP;
            rspValid <= 1'b1;
            loadOk   <= !selWe && !fault;
          end else begin
            state    <= WAIT;
            waitCnt  <= CNT_W'(WAIT_CYCLES);
          end
        end
        WAIT: begin
          waitCnt <= waitCnt - 1'b1;
          if (waitCnt == CNT_W'(1)) begin
            state    <= RESP;
            rspValid <= 1'b1;
            loadOk   <= !selWe && !fault;
          end
        end
        RESP: if (rsp_ready) begin
          state    <= IDLE;
          reqReady <= 1'b1;
          rspValid <= 1'b0;
          loadOk   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = reqReady;
  assign rsp_valid = rspValid;
  assign rsp_rdata = loadOk ? arrRdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: two responders (2 and 0 wait states) against a word-array reference model.
// Expectations follow DMEM_ERR_CHECK_EN when the bundle is compiled with it.
module tb_dmem_responder;

  logic        clk;
  logic        rst       [2];
  logic        reqValid  [2];
  logic        reqReady  [2];
  logic        reqWe     [2];
  logic [31:0] reqAddr   [2];
  logic [31:0] reqWdata  [2];
  logic [3:0]  reqBe     [2];
  logic        rspValid  [2];
  logic        rspReady  [2];
  logic [31:0] rspRdata  [2];
  logic        rspErr    [2];

  logic [31:0] refMem [2][1024];
  int unsigned nVec = 0;
  int unsigned nMis = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
    .req_we(reqWe[0]), .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]), .req_be(reqBe[0]),
    .rsp_valid(rspValid[0]), .rsp_ready(rspReady[0]), .rsp_rdata(rspRdata[0]), .rsp_err(rspErr[0])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst[1]), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
    .req_we(reqWe[1]), .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]), .req_be(reqBe[1]),
    .rsp_valid(rspValid[1]), .rsp_ready(rspReady[1]), .rsp_rdata(rspRdata[1]), .rsp_err(rspErr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int waitOf(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic logic isFault(input logic [31:0] a);
`ifdef DMEM_ERR_CHECK_EN
    return (a >= 32'h1000) || (a[1:0] != 2'b00);
`else
    return (a != a);
`endif
  endfunction

  // One complete transaction with model prediction, latency and hold checks.
  task automatic runTxn(input int i, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int hold, output logic [31:0] gotData);
    logic [31:0] expData;
    logic        expErr;
    int          idx;
    int          lat;
    idx     = int'((addr >> 2) % 1024);
    expErr  = isFault(addr);
    expData = (we || expErr) ? 32'h0 : refMem[i][idx];
    if (we && !expErr)
      for (int unsigned b = 0; b < 4; b++)
        if (be[b]) refMem[i][idx][8*b +: 8] = wdata[8*b +: 8];

    @(negedge clk);
    checkVal("reqReadyIdle", 32'(reqReady[i]), 32'd1);
    reqValid[i] = 1'b1;
    reqWe[i]    = we;
    reqAddr[i]  = addr;
    reqWdata[i] = wdata;
    reqBe[i]    = be;
    @(posedge clk);
    @(negedge clk);
    reqValid[i] = 1'b0;
    reqWe[i]    = 1'($urandom());
    reqAddr[i]  = $urandom();
    reqWdata[i] = $urandom();
    reqBe[i]    = 4'($urandom());
    lat = 1;
    while (!rspValid[i] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkVal("latency", 32'(lat), 32'(waitOf(i) + 1));
    checkVal("rdata", rspRdata[i], expData);
    checkVal("err", 32'(rspErr[i]), 32'(expErr));
    checkVal("reqReadyBusy", 32'(reqReady[i]), 32'd0);
    gotData = rspRdata[i];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkVal("holdValid", 32'(rspValid[i]), 32'd1);
      checkVal("holdRdata", rspRdata[i], expData);
      checkVal("holdReqReady", 32'(reqReady[i]), 32'd0);
    end
    rspReady[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rspReady[i] = 1'b0;
    checkVal("postValid", 32'(rspValid[i]), 32'd0);
    checkVal("postReqReady", 32'(reqReady[i]), 32'd1);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] addr;
    logic [31:0] expQ [$];
    int unsigned accepts;
    int unsigned k;

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; reqValid[i] = 1'b0; reqWe[i] = 1'b0; reqAddr[i] = '0;
      reqWdata[i] = '0; reqBe[i] = '0; rspReady[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checkVal("rstReqReady", 32'(reqReady[i]), 32'd1);
      checkVal("rstRspValid", 32'(rspValid[i]), 32'd0);
      checkVal("rstRdata", rspRdata[i], 32'd0);
      checkVal("rstErr", 32'(rspErr[i]), 32'd0);
    end

    // Give every word the traffic can reach a defined value.
    for (int i = 0; i < 2; i++)
      for (int unsigned w = 0; w < 64; w++)
        runTxn(i, 1'b1, 32'(w * 4), $urandom(), 4'hF, 0, got);

    runTxn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, got);
    runTxn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, got);
    checkVal("loadDeadbeef", got, 32'hDEADBEEF);
    runTxn(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 0, got);
    runTxn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, got);
    checkVal("loadMerged", got, 32'hDEADBEAA);
    runTxn(0, 1'b1, 32'h10, 32'h55555555, 4'b0000, 0, got);
    runTxn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, got);
    checkVal("beZeroStore", got, 32'hDEADBEAA);
    runTxn(0, 1'b0, 32'h12, 32'h0, 4'h0, 0, got);

    runTxn(0, 1'b0, 32'h1000, 32'h0, 4'h0, 0, got);
`ifdef DMEM_ERR_CHECK_EN
    checkVal("oobRdata", got, 32'h0);
`else
    checkVal("wrapRdata", got, refMem[0][0]);
`endif

    // Reset during the wait phase, once mid-count and once on the access edge.
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      reqValid[0] = 1'b1; reqWe[0] = 1'b1; reqAddr[0] = 32'h20;
      reqWdata[0] = 32'h12345678; reqBe[0] = 4'hF;
      @(posedge clk);
      @(negedge clk);
      reqValid[0] = 1'b0;
      repeat (d) @(negedge clk);
      rst[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst[0] = 1'b0;
      checkVal("abortReqReady", 32'(reqReady[0]), 32'd1);
      checkVal("abortValid", 32'(rspValid[0]), 32'd0);
      repeat (4) begin
        @(negedge clk);
        checkVal("abortNoRsp", 32'(rspValid[0]), 32'd0);
      end
      runTxn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, got);
    end

    // Zero wait states, request always pending, response always accepted.
    rspReady[1] = 1'b1;
    accepts = 0;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checkVal("b2bReqReady", 32'(reqReady[1]), 32'((c % 2) == 0));
      checkVal("b2bRspValid", 32'(rspValid[1]), 32'((c % 2) == 1));
      if (rspValid[1]) begin
        if (expQ.size() > 0) checkVal("b2bRdata", rspRdata[1], expQ.pop_front());
        else checkVal("b2bSpurious", 32'd1, 32'd0);
      end
      reqValid[1] = 1'b1;
      reqWe[1]    = 1'b0;
      reqAddr[1]  = 32'(k * 4);
      if (reqReady[1]) begin
        expQ.push_back(refMem[1][k]);
        accepts++;
        k++;
      end
    end
    reqValid[1] = 1'b0;
    @(negedge clk);
    rspReady[1] = 1'b0;
    checkVal("b2bAccepts", accepts, 32'd10);
    checkVal("b2bDrained", 32'(expQ.size()), 32'd0);
    checkVal("b2bIdle", 32'(reqReady[1]), 32'd1);

    for (int n = 0; n < 80; n++) begin
      int i;
      i = int'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 63) * 4);
      if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3) * 32'h1000);
      if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom());
      runTxn(i, 1'($urandom()), addr, $urandom(), 4'($urandom()),
             int'($urandom_range(0, 2)), got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
